// File: rtl/axi4_slave_pkg.sv
// Shared constants, FSM encodings and request decode for the AXI4 burst slave.
package axi4_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] SIZE_4B     = 3'b010;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Only full-word FIXED/INCR bursts touch memory; anything else completes with SLVERR.
    function automatic logic req_err(input logic [1:0] burst, input logic [2:0] size);
        return (burst == BURST_WRAP) || (burst == 2'b11) || (size != SIZE_4B);
    endfunction

endpackage

// File: rtl/axi4_slave_mem.sv
// Word memory: one byte-enabled synchronous write port, one asynchronous read port.
module axi4_slave_mem #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [3:0]        wstrb_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axi4_burst_slave_mem.sv
// AXI4 slave endpoint backed by a word-addressed memory; independent write and read FSMs.
//
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting LEN+1 beats
//   W_RESP | BVALID high until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID high, streaming LEN+1 beats
module axi4_burst_slave_mem
    import axi4_slave_pkg::*;
#(
    parameter int MEM_WORDS_LOG2     = 10,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [7:0]                    S_AXI_AWLEN,
    input  logic [2:0]                    S_AXI_AWSIZE,
    input  logic [1:0]                    S_AXI_AWBURST,
    input  logic                          S_AXI_AWLOCK,
    input  logic [3:0]                    S_AXI_AWCACHE,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic [3:0]                    S_AXI_AWREGION,
    input  logic [3:0]                    S_AXI_AWQOS,
    input  logic                          S_AXI_AWUSER,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic                          S_AXI_WID,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WLAST,
    input  logic                          S_AXI_WUSER,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic                          S_AXI_BID,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BUSER,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic                          S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [7:0]                    S_AXI_ARLEN,
    input  logic [2:0]                    S_AXI_ARSIZE,
    input  logic [1:0]                    S_AXI_ARBURST,
    input  logic                          S_AXI_ARLOCK,
    input  logic [3:0]                    S_AXI_ARCACHE,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic [3:0]                    S_AXI_ARREGION,
    input  logic [3:0]                    S_AXI_ARQOS,
    input  logic                          S_AXI_ARUSER,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic                          S_AXI_RID,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RLAST,
    output logic                          S_AXI_RUSER,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY
);

    localparam int IW = MEM_WORDS_LOG2;
    localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

    logic [1:0]    wstate_q, wstate_d;
    logic          awready_q, wready_q, bvalid_q, bid_q;
    logic [1:0]    bresp_q;
    logic          werr_q, wlerr_q, winc_q;
    logic [IW-1:0] widx_q;
    logic [7:0]    wbeats_q;

    logic [0:0]    rstate_q, rstate_d;
    logic          arready_q, rvalid_q, rlast_q, rid_q;
    logic [1:0]    rresp_q;
    logic [31:0]   rdata_q;
    logic          rerr_q, rinc_q;
    logic [IW-1:0] ridx_q;
    logic [7:0]    rbeats_q;

    logic          aw_hs, w_hs, w_final, wlast_bad, mem_we;
    logic          ar_hs, r_hs, ar_err;
    logic [IW-1:0] ar_idx, ridx_nxt, mem_raddr;
    logic [31:0]   mem_rdata;

    assign aw_hs     = S_AXI_AWVALID && awready_q;
    assign w_hs      = S_AXI_WVALID && wready_q;
    assign w_final   = (wbeats_q == 8'd0);
    assign wlast_bad = (S_AXI_WLAST != w_final);
    assign mem_we    = w_hs && !werr_q;

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs) wstate_d = W_DATA;
            W_DATA:  if (w_hs && w_final) wstate_d = W_RESP;
            W_RESP:  if (S_AXI_BREADY) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= 1'b0;
            werr_q    <= 1'b0;
            wlerr_q   <= 1'b0;
            winc_q    <= 1'b0;
            widx_q    <= '0;
            wbeats_q  <= 8'd0;
        end else begin
            wstate_q <= wstate_d;
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        bid_q     <= S_AXI_AWID;
                        widx_q    <= S_AXI_AWADDR[IW+1:2];
                        wbeats_q  <= S_AXI_AWLEN;
                        werr_q    <= req_err(S_AXI_AWBURST, S_AXI_AWSIZE);
                        winc_q    <= (S_AXI_AWBURST == BURST_INCR);
                        wlerr_q   <= 1'b0;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        if (winc_q) widx_q <= widx_q + IDX_ONE;
                        wbeats_q <= wbeats_q - 8'd1;
                        if (wlast_bad) wlerr_q <= 1'b1;
                        // Beat count comes from AWLEN; a WLAST mismatch only taints the response.
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (werr_q || wlerr_q || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ar_hs     = S_AXI_ARVALID && arready_q;
    assign r_hs      = rvalid_q && S_AXI_RREADY;
    assign ar_err    = req_err(S_AXI_ARBURST, S_AXI_ARSIZE);
    assign ar_idx    = S_AXI_ARADDR[IW+1:2];
    assign ridx_nxt  = rinc_q ? (ridx_q + IDX_ONE) : ridx_q;
    // Read data is registered from the async port, so a same-edge write is seen as old data.
    assign mem_raddr = (rstate_q == R_IDLE) ? ar_idx : ridx_nxt;

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs && rlast_q) rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= 1'b0;
            rerr_q    <= 1'b0;
            rinc_q    <= 1'b0;
            ridx_q    <= '0;
            rbeats_q  <= 8'd0;
        end else begin
            rstate_q <= rstate_d;
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= S_AXI_ARID;
                        ridx_q    <= ar_idx;
                        rbeats_q  <= S_AXI_ARLEN;
                        rerr_q    <= ar_err;
                        rinc_q    <= (S_AXI_ARBURST == BURST_INCR);
                        rdata_q   <= ar_err ? 32'd0 : mem_rdata;
                        rlast_q   <= (S_AXI_ARLEN == 8'd0);
                        rresp_q   <= ar_err ? RESP_SLVERR : RESP_OKAY;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q <= 1'b0;
                        end else begin
                            ridx_q   <= ridx_nxt;
                            rbeats_q <= rbeats_q - 8'd1;
                            rdata_q  <= rerr_q ? 32'd0 : mem_rdata;
                            rlast_q  <= (rbeats_q == 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    axi4_slave_mem #(.ADDR_W(IW)) u_mem (
        .clk_i   (ACLK),
        .we_i    (mem_we),
        .wstrb_i (S_AXI_WSTRB),
        .waddr_i (widx_q),
        .wdata_i (S_AXI_WDATA),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BID     = bid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_BUSER   = 1'b0;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RID     = rid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign S_AXI_RUSER   = 1'b0;
    assign S_AXI_RVALID  = rvalid_q;

    logic unused_sideband;
    assign unused_sideband = ^{S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWREGION,
                               S_AXI_AWQOS, S_AXI_AWUSER, S_AXI_WID, S_AXI_WUSER,
                               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARREGION,
                               S_AXI_ARQOS, S_AXI_ARUSER,
                               S_AXI_AWADDR[1:0], S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:IW+2],
                               S_AXI_ARADDR[1:0], S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:IW+2]};

endmodule
